// File: rtl/uart_cmd_pkg.sv
// Shared types and default parameter values for the UART command assembler.
package uart_cmd_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_ACCUM
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_t;

  localparam int unsigned DEF_CMD_BYTES   = 2;
  localparam int unsigned DEF_RESP_BYTES  = 1;
  localparam int unsigned DEF_TIMEOUT_CYC = 65536;

endpackage

// File: rtl/resp_serializer.sv
// Response serializer: latches a multi-byte response word and hands it to the
// UART core one byte at a time, most significant byte first, pacing each byte
// on the core's tx_done pulse.
module resp_serializer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned RESP_BYTES = DEF_RESP_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    resp_trmt,
  input  logic [8*RESP_BYTES-1:0] resp_data,
  output logic                    resp_busy,
  output logic                    resp_tx_done,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int unsigned RW     = 8 * RESP_BYTES;
  localparam int unsigned LEFT_W = $clog2(RESP_BYTES + 1);

  tx_state_t         tx_state;
  logic [RW-1:0]     shreg;
  logic [LEFT_W-1:0] bytes_left;

  // TX FSM: accept a response, then alternate byte start / wait for completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      shreg        <= '0;
      bytes_left   <= '0;
      resp_busy    <= 1'b0;
      resp_tx_done <= 1'b0;
      trmt         <= 1'b0;
      tx_data      <= '0;
    end else begin
      trmt         <= 1'b0;
      resp_tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (resp_trmt) begin
            shreg      <= resp_data;
            bytes_left <= LEFT_W'(RESP_BYTES);
            resp_busy  <= 1'b1;
            tx_state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          trmt       <= 1'b1;
          tx_data    <= shreg[RW-1 -: 8];
          shreg      <= shreg << 8;
          bytes_left <= bytes_left - LEFT_W'(1);
          tx_state   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            if (bytes_left != '0) begin
              tx_state <= TX_SEND;
            end else begin
              resp_tx_done <= 1'b1;
              resp_busy    <= 1'b0;
              tx_state     <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// UART command assembler: gathers CMD_BYTES received bytes into one command
// word (first byte in the MS byte) and serializes RESP_BYTES-byte responses.
// Define CMD_TIMEOUT_EN to discard a partial command after an inter-byte gap
// of TIMEOUT_CYC clock cycles.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CMD_BYTES   = DEF_CMD_BYTES,
  parameter int unsigned RESP_BYTES  = DEF_RESP_BYTES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    cmd_ovr,
  output logic                    rx_timeout,
  input  logic                    resp_trmt,
  input  logic [8*RESP_BYTES-1:0] resp_data,
  output logic                    resp_busy,
  output logic                    resp_tx_done,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int unsigned CW    = 8 * CMD_BYTES;
  localparam int unsigned CNT_W = $clog2(CMD_BYTES);

  rx_state_t        rx_state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    word_next;
  logic             cmd_done;
  logic             gap_hit;

  // Every byte offered by the UART core is consumed immediately.
  assign clr_rx_rdy = rx_rdy;

  assign word_next = {acc[CW-9:0], rx_data};
  assign cmd_done  = rx_rdy && (rx_state == RX_ACCUM) &&
                     (byte_cnt == CNT_W'(CMD_BYTES - 1));

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);

  logic [GAP_W-1:0] gap_cnt;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign gap_hit = (rx_state == RX_ACCUM) && !rx_rdy &&
                   (gap_cnt == GAP_W'(TIMEOUT_CYC - 1));

  // Inter-byte gap counter; runs only while a command is partially assembled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt    <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= gap_hit;
      if (rx_rdy || (rx_state != RX_ACCUM) || gap_hit) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end
`else
  assign gap_hit    = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  // RX FSM: shift bytes in, hand off completed words, flag dropped words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      byte_cnt <= '0;
      acc      <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      cmd_ovr  <= 1'b0;
    end else begin
      cmd_ovr <= 1'b0;
      if (rx_rdy) begin
        if (rx_state == RX_IDLE) begin
          acc      <= word_next;
          byte_cnt <= CNT_W'(1);
          rx_state <= RX_ACCUM;
        end else if (cmd_done) begin
          acc      <= '0;
          byte_cnt <= '0;
          rx_state <= RX_IDLE;
          // A clear in the completion cycle frees the slot for the new word.
          if (cmd_rdy && !clr_cmd_rdy) begin
            cmd_ovr <= 1'b1;
          end else begin
            cmd <= word_next;
          end
        end else begin
          acc      <= word_next;
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end else if (gap_hit) begin
        acc      <= '0;
        byte_cnt <= '0;
        rx_state <= RX_IDLE;
      end

      if (cmd_done) begin
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  resp_serializer #(
    .RESP_BYTES(RESP_BYTES)
  ) u_resp_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .resp_trmt   (resp_trmt),
    .resp_data   (resp_data),
    .resp_busy   (resp_busy),
    .resp_tx_done(resp_tx_done),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

endmodule
